// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants, request format codes and encoder FSM states.
// Imported by the immediate packer, the encoder top and its interface users.
package rv_isa_pkg;

    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_S  = 3'd1,
        FMT_B  = 3'd2,
        FMT_J  = 3'd3,
        FMT_U  = 3'd4,
        FMT_LI = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI   = 3'b000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WORD = 1'b1
    } state_e;

    // True when v[31:msb] are all copies of the same bit, i.e. v fits in msb+1 signed bits.
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic [31:0] t;
        t = $signed(v) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/instr_imm_encoder_if.sv
// Request and instruction-word handshake bundle of the immediate encoder.
// master = requester/consumer side, slave = encoder side.
interface instr_imm_encoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_fmt;
    logic [6:0]           req_opcode;
    logic [2:0]           req_funct3;
    logic [4:0]           req_rd;
    logic [4:0]           req_rs1;
    logic [4:0]           req_rs2;
    logic [31:0]          req_imm;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic                 out_last;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output req_valid, req_fmt, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready,
        input  out_valid, out_instr, out_last, out_err, err_count,
        output out_ready
    );

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready,
        output out_valid, out_instr, out_last, out_err, err_count,
        input  out_ready
    );

endinterface

// File: rtl/imm_field_pack.sv
// Combinational RV32I field packer: scatters the immediate into I/S/B/J/U layouts and flags
// immediates the format cannot represent. Zero latency, no handshake.
module imm_field_pack
    import rv_isa_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_err
);

    always_comb begin
        instr     = 32'h0000_0000;
        range_err = 1'b1;
        case (fmt)
            FMT_I: begin
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !fits_signed(imm, 11);
            end
            FMT_S: begin
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !fits_signed(imm, 11);
            end
            FMT_B: begin
                instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !fits_signed(imm, 12) || imm[0];
            end
            FMT_J: begin
                instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !fits_signed(imm, 20) || imm[0];
            end
            FMT_U: begin
                instr     = {imm[31:12], rd, opcode};
                range_err = (imm[11:0] != 12'h000);
            end
            // LI never reaches here (the top rewrites it); reserved codes emit a zero word.
            default: begin
                instr     = 32'h0000_0000;
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_imm_encoder.sv
// Packs register-level requests plus a 32-bit immediate into RV32I words; LI becomes ADDI or LUI+ADDI.
// First word one cycle after accept; words hold under out_ready=0, req_ready follows out_ready combinationally.
module instr_imm_encoder
    import rv_isa_pkg::*;
#(
    parameter int LI_OPT    = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    instr_imm_encoder_if.slave  bus
);

    state_e               state;
    logic                 pend2;
    logic [31:0]          word2;
    logic                 word2_err;
    logic                 out_valid_q;
    logic [31:0]          out_instr_q;
    logic                 out_last_q;
    logic                 out_err_q;
    logic [ERR_CNT_W-1:0] err_cnt;

    fmt_e        req_fmt;
    logic [31:0] li_sum;
    logic [31:0] lo_sext;
    logic        is_li;
    logic        li_single;
    logic        li_pair;
    logic        accept;

    fmt_e        p_fmt;
    logic [6:0]  p_opcode;
    logic [2:0]  p_funct3;
    logic [4:0]  p_rs1;
    logic [31:0] p_imm;
    logic [31:0] pk_instr;
    logic        pk_err;
    logic [31:0] addi_instr;
    logic        addi_err;

    assign req_fmt   = fmt_e'(bus.req_fmt);
    assign li_sum    = bus.req_imm + 32'h0000_0800;
    assign lo_sext   = {{20{bus.req_imm[11]}}, bus.req_imm[11:0]};
    assign is_li     = (req_fmt == FMT_LI);
    assign li_single = is_li && (LI_OPT != 0) && fits_signed(bus.req_imm, 11);
    assign li_pair   = is_li && !li_single;

    assign bus.req_ready = !rst && ((state == S_IDLE) ||
                                    ((state == S_WORD) && bus.out_ready && !pend2));
    assign accept        = bus.req_valid && bus.req_ready;

    // LI is rewritten into an ordinary I (ADDI) or U (LUI) request for the first word.
    always_comb begin
        p_fmt    = req_fmt;
        p_opcode = bus.req_opcode;
        p_funct3 = bus.req_funct3;
        p_rs1    = bus.req_rs1;
        p_imm    = bus.req_imm;
        if (li_single) begin
            p_fmt    = FMT_I;
            p_opcode = OPC_OPIMM;
            p_funct3 = F3_ADDI;
            p_rs1    = 5'd0;
            p_imm    = lo_sext;
        end else if (li_pair) begin
            p_fmt    = FMT_U;
            p_opcode = OPC_LUI;
            p_imm    = {li_sum[31:12], 12'h000};
        end
    end

    imm_field_pack u_pack_first (
        .fmt       (p_fmt),
        .opcode    (p_opcode),
        .funct3    (p_funct3),
        .rd        (bus.req_rd),
        .rs1       (p_rs1),
        .rs2       (bus.req_rs2),
        .imm       (p_imm),
        .instr     (pk_instr),
        .range_err (pk_err)
    );

    // ADDI rd,rd,lo that follows a LUI; captured at accept so request fields may change freely.
    imm_field_pack u_pack_addi (
        .fmt       (FMT_I),
        .opcode    (OPC_OPIMM),
        .funct3    (F3_ADDI),
        .rd        (bus.req_rd),
        .rs1       (bus.req_rd),
        .rs2       (5'd0),
        .imm       (lo_sext),
        .instr     (addi_instr),
        .range_err (addi_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pend2       <= 1'b0;
            word2       <= 32'h0000_0000;
            word2_err   <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            err_cnt     <= '0;
        end else if (accept) begin
            state       <= S_WORD;
            out_valid_q <= 1'b1;
            out_instr_q <= pk_instr;
            out_last_q  <= !li_pair;
            out_err_q   <= pk_err;
            pend2       <= li_pair;
            word2       <= addi_instr;
            word2_err   <= addi_err;
            if (pk_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end else if ((state == S_WORD) && bus.out_ready) begin
            if (pend2) begin
                out_instr_q <= word2;
                out_last_q  <= 1'b1;
                out_err_q   <= word2_err;
                pend2       <= 1'b0;
            end else begin
                state       <= S_IDLE;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_count = err_cnt;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Bench for instr_imm_encoder: directed checks plus random requests against an arithmetic model.
module tb_instr_imm_encoder;

    localparam int LI_OPT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_imm_encoder_if #(.ERR_CNT_W(8)) bus ();

    instr_imm_encoder #(.LI_OPT(LI_OPT), .ERR_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        lst;
        logic        err;
        logic        rt;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   exp_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   bp_mode = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [31:0] imm);
        return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
               (32'(rd) << 7) | 32'(opc);
    endfunction

    // Reference: field placement by shifts, legality by signed integer ranges.
    task automatic model(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, output exp_t w0, output exp_t w1, output int n);
        longint sv;
        logic   ok;
        logic [31:0] ins;
        logic [31:0] hi;
        sv  = longint'($signed(imm));
        ok  = 1'b0;
        ins = 32'h0;
        n   = 1;
        w1  = '{32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
        case (fmt)
            3'd0: begin
                ok  = (sv >= -2048) && (sv <= 2047);
                ins = enc_i(opc, f3, rd, rs1, imm);
            end
            3'd1: begin
                ok  = (sv >= -2048) && (sv <= 2047);
                ins = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
                      (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(opc);
            end
            3'd2: begin
                ok  = (sv >= -4096) && (sv <= 4094) && (sv % 2 == 0);
                ins = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                      (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
                      (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(opc);
            end
            3'd3: begin
                ok  = (sv >= -1048576) && (sv <= 1048574) && (sv % 2 == 0);
                ins = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                      (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                      (32'(rd) << 7) | 32'(opc);
            end
            3'd4: begin
                ok  = ((imm & 32'hFFF) == 32'h0);
                ins = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(opc);
            end
            default: begin
                ok  = 1'b0;
                ins = 32'h0;
            end
        endcase
        w0 = '{ins, 1'b1, !ok, ok, fmt, imm};
        if (fmt == 3'd5) begin
            if ((LI_OPT != 0) && (sv >= -2048) && (sv <= 2047)) begin
                w0 = '{enc_i(7'h13, 3'd0, rd, 5'd0, imm), 1'b1, 1'b0, 1'b0, fmt, imm};
            end else begin
                hi = (imm + 32'h800) >> 12;
                w0 = '{(hi << 12) | (32'(rd) << 7) | 32'h37, 1'b0, 1'b0, 1'b0, fmt, imm};
                w1 = '{enc_i(7'h13, 3'd0, rd, rd, imm), 1'b1, 1'b0, 1'b0, fmt, imm};
                n  = 2;
            end
        end
    endtask

    // Immediate generator (decoder side), used for the round-trip check.
    function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] i);
        case (fmt)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'h000};
        endcase
    endfunction

    // Compare process: every non-reset cycle, before folding in this cycle's accept.
    always @(negedge clk) begin
        exp_t w0, w1;
        int   n;
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            chk("err_count", 64'(bus.err_count), 64'(exp_cnt));
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            if (bus.out_valid && q.size() != 0) begin
                chk("word", {30'h0, bus.out_instr, bus.out_last, bus.out_err},
                    {30'h0, q[0].instr, q[0].lst, q[0].err});
                if (q[0].rt)
                    chk("roundtrip", 64'(dec_imm(q[0].fmt, bus.out_instr)), 64'(q[0].imm));
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.req_valid && bus.req_ready) begin
                model(bus.req_fmt, bus.req_opcode, bus.req_funct3, bus.req_rd, bus.req_rs1,
                      bus.req_rs2, bus.req_imm, w0, w1, n);
                q.push_back(w0);
                if (n == 2) q.push_back(w1);
                if (w0.err && exp_cnt < 255) exp_cnt++;
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, output int waited);
        logic acc;
        bus.req_fmt    = f;
        bus.req_opcode = o;
        bus.req_funct3 = f3;
        bus.req_rd     = rd;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.req_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: request fmt %0d not accepted within 200 cycles", f);
        end
    endtask

    initial begin
        exp_t a, b;
        int   n, w, t0;
        logic [31:0] held, base, imm;
        logic [2:0]  f;
        bus.req_valid = 1'b0;
        bus.req_fmt = 3'd0; bus.req_opcode = 7'd0; bus.req_funct3 = 3'd0;
        bus.req_rd = 5'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_imm = 32'd0;

        // Pin the model to hand-computed words.
        model(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, a, b, n);
        chk("pin_i", 64'(a.instr), 64'h FFF3_0293);
        model(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, a, b, n);
        chk("pin_li_w1", 64'(a.instr), 64'h1234_6537);
        chk("pin_li_w2", 64'(b.instr), 64'hFFF5_0513);
        model(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h7FFF_F800, a, b, n);
        chk("pin_li_wrap", {a.instr, b.instr}, 64'h8000_0537_8005_0513);
        model(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'hFFFF_FFFB, a, b, n);
        chk("pin_li_single", {32'(n), a.instr}, {32'd1, 32'hFFB0_0513});
        model(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd13, a, b, n);
        chk("pin_b_odd", 64'(a.err), 64'd1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_last_err", {bus.out_last, bus.out_err}, 64'd0);
        chk("rst_err_count", 64'(bus.err_count), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        nxt();
        rst = 1'b0;
        bp_mode = 0;
        nxt();

        // I format, one cycle latency
        send(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, w);
        @(negedge clk);
        chk("i_valid", 64'(bus.out_valid), 64'd1);
        chk("i_word", {bus.out_instr, bus.out_last, bus.out_err}, {32'hFFF3_0293, 1'b1, 1'b0});
        nxt();

        // B odd offset: error, still emitted
        send(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd13, w);
        @(negedge clk);
        chk("b_odd_err", {bus.out_valid, bus.out_err}, 64'b11);
        chk("b_odd_count", 64'(bus.err_count), 64'd1);
        nxt();
        send(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, w);
        @(negedge clk);
        chk("b_min_bits", {bus.out_instr[31], bus.out_instr[7], bus.out_err}, 64'b100);
        nxt();

        // LI with 10 cycles of back-pressure on word1
        bp_mode = 1;
        send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, w);
        @(negedge clk);
        chk("li_w1", {bus.out_instr, bus.out_last}, {32'h1234_6537, 1'b0});
        held = bus.out_instr;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("li_hold", {bus.out_valid, bus.req_ready, bus.out_instr}, {1'b1, 1'b0, held});
        end
        nxt();
        bp_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("li_w2", {bus.out_instr, bus.out_last}, {32'hFFF5_0513, 1'b1});
        nxt();
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            send(3'd0, 7'h13, 3'd0, 5'(i + 1), 5'd2, 5'd0, 32'(i * 100), w);
        chk("b2b_cycles", 64'(cyc - t0), 64'd4);

        // LI hi wrap, and single-ADDI LI
        send(3'd5, 7'h00, 3'd0, 5'd3, 5'd0, 5'd0, 32'h7FFF_F800, w);
        @(negedge clk);
        chk("li_wrap_w1", 64'(bus.out_instr), 64'h8000_01B7);
        @(negedge clk);
        chk("li_wrap_w2", 64'(bus.out_instr), 64'h8001_8193);
        nxt();
        send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'hFFFF_FFFB, w);
        @(negedge clk);
        chk("li_single", {bus.out_instr, bus.out_last}, {32'hFFB0_0513, 1'b1});
        nxt();

        // Reserved fmt
        send(3'd6, 7'h7F, 3'd7, 5'd1, 5'd1, 5'd1, 32'h1234_5678, w);
        @(negedge clk);
        chk("rsv_word", {bus.out_instr, bus.out_last, bus.out_err}, {32'h0, 1'b1, 1'b1});
        nxt();

        // Reset while the second LI word is owed
        bp_mode = 1;
        nxt();
        send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, w);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pend_state", {bus.out_valid, 8'(bus.err_count)}, 64'd0);
        nxt();
        rst = 1'b0;
        bp_mode = 0;
        send(3'd1, 7'h23, 3'd2, 5'd0, 5'd4, 5'd9, 32'hFFFF_FFF0, w);
        chk("accept_after_rst", 64'(w), 64'd1);

        // Random traffic with random back-pressure
        bp_mode = 2;
        for (int i = 0; i < 400; i++) begin
            n    = $urandom_range(0, 15);
            f    = (n < 14) ? 3'(n % 6) : 3'(6 + (n & 1));
            base = $urandom;
            case (f)
                3'd0, 3'd1: imm = {{20{base[11]}}, base[11:0]};
                3'd2:       imm = {{19{base[12]}}, base[12:1], 1'b0};
                3'd3:       imm = {{11{base[20]}}, base[20:1], 1'b0};
                3'd4:       imm = base & 32'hFFFF_F000;
                default:    imm = base[0] ? base : {{20{base[11]}}, base[11:0]};
            endcase
            if ($urandom_range(0, 7) == 0) imm = base;
            send(f, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 imm, w);
        end

        // Drive the error counter into saturation
        bp_mode = 0;
        for (int i = 0; i < 260; i++)
            send(3'd7, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, w);
        @(negedge clk);
        @(negedge clk);
        chk("err_saturate", 64'(bus.err_count), 64'd255);

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

endmodule
